tdc_meas_sequencer: RTL and testbench

//  Sequences the time-to-digital converter on the 100 MHz domain: arms one measurement,

---
 rtl/tdc_meas_sequencer.sv | 173 +++++++++++++++++
 tb/tb_tdc_meas_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_sequencer.sv
// TDC measurement sequencer: arms the TDC, waits for a result or timeout, and streams
// an 8-byte record (header, seq, coarse, fine, flags, checksum) to the UART transmitter.
module tdc_meas_sequencer #(
    parameter int unsigned COARSE_W    = 24,
    parameter int unsigned FINE_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 100_000_000,
    parameter int unsigned HOLDOFF_CYC = 1000
) (
    input  logic                i_clk_100m,
    input  logic                i_rst,
    input  logic                i_enable,
    output logic                o_tdc_arm,
    input  logic                i_tdc_valid,
    input  logic [COARSE_W-1:0] i_tdc_coarse,
    input  logic [FINE_W-1:0]   i_tdc_fine,
    input  logic                i_tdc_overflow,
    output logic                o_tx_valid,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_ready,
    output logic                o_busy,
    output logic                o_timeout_pulse
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
    localparam int unsigned HO_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYC - 1);

    typedef enum logic [2:0] {StIdle, StArm, StWait, StSend, StHold} state_e;

    state_e          r_state;
    logic            r_tdc_arm;
    logic            r_tx_valid;
    logic [7:0]      r_tx_data;
    logic            r_busy;
    logic            r_timeout_pulse;
    logic [23:0]     r_coarse;
    logic [7:0]      r_fine;
    logic [2:0]      r_flags;
    logic [7:0]      r_seq;
    logic            r_missed;
    logic [2:0]      r_idx;
    logic [TO_W-1:0] r_to_cnt;
    logic [HO_W-1:0] r_hold_cnt;

    logic [23:0]     w_coarse_ext;
    logic [7:0]      w_fine_ext;
    logic [2:0]      w_idx_next;
    logic [7:0]      w_chk;
    logic [7:0]      w_byte_next;
    logic            w_stray_valid;

    assign w_coarse_ext  = 24'(i_tdc_coarse);
    assign w_fine_ext    = 8'(i_tdc_fine);
    assign w_idx_next    = r_idx + 3'd1;
    assign w_stray_valid = i_tdc_valid & (r_state != StWait);
    assign w_chk = r_seq ^ r_coarse[23:16] ^ r_coarse[15:8] ^ r_coarse[7:0] ^ r_fine
                 ^ {5'b0, r_flags};

    always_comb begin
        w_byte_next = 8'hA5;
        case (w_idx_next)
            3'd1:    w_byte_next = r_seq;
            3'd2:    w_byte_next = r_coarse[23:16];
            3'd3:    w_byte_next = r_coarse[15:8];
            3'd4:    w_byte_next = r_coarse[7:0];
            3'd5:    w_byte_next = r_fine;
            3'd6:    w_byte_next = {5'b0, r_flags};
            3'd7:    w_byte_next = w_chk;
            default: w_byte_next = 8'hA5;
        endcase
    end

    always_ff @(posedge i_clk_100m) begin
        if (i_rst) begin
            r_state         <= StIdle;
            r_tdc_arm       <= 1'b0;
            r_tx_valid      <= 1'b0;
            r_tx_data       <= 8'h00;
            r_busy          <= 1'b0;
            r_timeout_pulse <= 1'b0;
            r_coarse        <= '0;
            r_fine          <= '0;
            r_flags         <= '0;
            r_seq           <= '0;
            r_missed        <= 1'b0;
            r_idx           <= '0;
            r_to_cnt        <= '0;
            r_hold_cnt      <= '0;
        end else begin
            r_timeout_pulse <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_enable) begin
                        r_state <= StArm;
                        r_busy  <= 1'b1;
                    end
                end
                StArm: begin
                    r_to_cnt <= '0;
                    if (i_enable) begin
                        r_state   <= StWait;
                        r_tdc_arm <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                StWait: begin
                    if (!i_enable) begin
                        r_state   <= StIdle;
                        r_tdc_arm <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (i_tdc_valid) begin
                        // A result arriving on the timeout cycle still counts as a result.
                        r_coarse   <= w_coarse_ext;
                        r_fine     <= w_fine_ext;
                        r_flags    <= {r_missed, i_tdc_overflow, 1'b0};
                        r_tdc_arm  <= 1'b0;
                        r_idx      <= '0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= 8'hA5;
                        r_state    <= StSend;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_coarse        <= '0;
                        r_fine          <= '0;
                        r_flags         <= {r_missed, 1'b0, 1'b1};
                        r_timeout_pulse <= 1'b1;
                        r_tdc_arm       <= 1'b0;
                        r_idx           <= '0;
                        r_tx_valid      <= 1'b1;
                        r_tx_data       <= 8'hA5;
                        r_state         <= StSend;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                StSend: begin
                    if (i_tx_ready) begin
                        if (r_idx == 3'd7) begin
                            r_tx_valid <= 1'b0;
                            r_seq      <= r_seq + 8'd1;
                            r_missed   <= 1'b0;
                            r_hold_cnt <= '0;
                            r_state    <= StHold;
                        end else begin
                            r_idx     <= w_idx_next;
                            r_tx_data <= w_byte_next;
                        end
                    end
                end
                StHold: begin
                    if (r_hold_cnt == HO_LAST) begin
                        r_state <= i_enable ? StArm : StIdle;
                        r_busy  <= i_enable;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Placed after the case so a stray result beats the end-of-record clear.
            if (w_stray_valid) r_missed <= 1'b1;
        end
    end

    assign o_tdc_arm       = r_tdc_arm;
    assign o_tx_valid      = r_tx_valid;
    assign o_tx_data       = r_tx_data;
    assign o_busy          = r_busy;
    assign o_timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Bench for tdc_meas_sequencer: timestamp/queue based reference model checked every cycle,
// plus hand-computed record bytes and timing literals.
module tb_tdc_meas_sequencer;

    localparam int unsigned TO = 50;
    localparam int unsigned HO = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        v;
    logic [23:0] coarse;
    logic [7:0]  fine;
    logic        ovf;
    logic        rdy;
    logic        arm;
    logic        txv;
    logic [7:0]  txd;
    logic        busy;
    logic        to_p;

    tdc_meas_sequencer #(
        .COARSE_W    (24),
        .FINE_W      (8),
        .TIMEOUT_CYC (TO),
        .HOLDOFF_CYC (HO)
    ) dut (
        .i_clk_100m      (clk),
        .i_rst           (rst),
        .i_enable        (en),
        .o_tdc_arm       (arm),
        .i_tdc_valid     (v),
        .i_tdc_coarse    (coarse),
        .i_tdc_fine      (fine),
        .i_tdc_overflow  (ovf),
        .o_tx_valid      (txv),
        .o_tx_data       (txd),
        .i_tx_ready      (rdy),
        .o_busy          (busy),
        .o_timeout_pulse (to_p)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: phase of the measurement cycle, absolute deadlines, pending bytes.
    typedef enum int {M_IDLE, M_ARMING, M_WAITING, M_SENDING, M_HOLDING} mphase_t;
    mphase_t      ph = M_IDLE;
    longint       cyc = 0;
    longint       deadline = 0;
    longint       hold_end = 0;
    logic [7:0]   recq[$];
    logic [7:0]   dut_log[$];
    logic [7:0]   m_log[$];
    int unsigned  m_seq = 0;
    bit           m_missed = 1'b0;
    bit           live = 1'b0;
    int           n_done = 0;
    bit           e_arm = 1'b0;
    bit           e_txv = 1'b0;
    bit           e_busy = 1'b0;
    bit           e_to = 1'b0;
    logic [7:0]   e_txd = 8'h00;

    function automatic void start_record(input logic [23:0] c, input logic [7:0] f,
                                         input bit o, input bit t);
        logic [7:0] b[8];
        b[0] = 8'hA5;
        b[1] = 8'(m_seq);
        b[2] = c[23:16];
        b[3] = c[15:8];
        b[4] = c[7:0];
        b[5] = f;
        b[6] = {5'b0, m_missed, o, t};
        b[7] = 8'h00;
        for (int i = 1; i < 7; i++) b[7] = b[7] ^ b[i];
        recq.delete();
        for (int i = 0; i < 8; i++) recq.push_back(b[i]);
        e_txd = recq.pop_front();
        e_txv = 1'b1;
        e_arm = 1'b0;
        ph    = M_SENDING;
    endfunction

    function automatic void model_step();
        bit stray;
        cyc++;
        if (rst) begin
            ph = M_IDLE; e_arm = 0; e_txv = 0; e_busy = 0; e_to = 0; e_txd = 8'h00;
            m_seq = 0; m_missed = 0; recq.delete(); live = 1;
            return;
        end
        stray = v && (ph != M_WAITING);
        e_to = 1'b0;
        case (ph)
            M_IDLE: if (en) ph = M_ARMING;
            M_ARMING: begin
                if (!en) ph = M_IDLE;
                else begin
                    ph = M_WAITING; e_arm = 1'b1; deadline = cyc + TO;
                end
            end
            M_WAITING: begin
                if (!en) begin
                    ph = M_IDLE; e_arm = 1'b0;
                end else if (v) begin
                    start_record(coarse, fine, ovf, 1'b0);
                end else if (cyc == deadline) begin
                    start_record(24'h0, 8'h0, 1'b0, 1'b1);
                    e_to = 1'b1;
                end
            end
            M_SENDING: begin
                if (e_txv && rdy) begin
                    m_log.push_back(e_txd);
                    if (recq.size() == 0) begin
                        e_txv = 1'b0; m_seq = (m_seq + 1) % 256; m_missed = 1'b0;
                        ph = M_HOLDING; hold_end = cyc + HO; n_done++;
                    end else begin
                        e_txd = recq.pop_front();
                    end
                end
            end
            M_HOLDING: if (cyc == hold_end) ph = en ? M_ARMING : M_IDLE;
            default: ph = M_IDLE;
        endcase
        if (stray) m_missed = 1'b1;
        e_busy = (ph != M_IDLE);
    endfunction

    // Compare DUT state after the last edge, then advance the model across the next edge.
    always @(negedge clk) begin
        if (live) begin
            check("tdc_arm", 32'(arm), 32'(e_arm));
            check("busy", 32'(busy), 32'(e_busy));
            check("tx_valid", 32'(txv), 32'(e_txv));
            check("timeout_pulse", 32'(to_p), 32'(e_to));
            if (e_txv) check("tx_data", 32'(txd), 32'(e_txd));
            if (txv && rdy) dut_log.push_back(txd);
        end
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ph(input mphase_t p, input int lim, input string nm);
        int k = 0;
        while (ph != p && k < lim) begin tick(); k++; end
        if (ph != p) begin
            n_vec++; n_miss++;
            $display("FAIL %s: phase %0d not reached in %0d cycles", nm, p, lim);
        end
    endtask

    task automatic wait_bytes(input int target, input int lim, input string nm);
        int k = 0;
        while (dut_log.size() < target && k < lim) begin tick(); k++; end
        check(nm, 32'(dut_log.size() >= target), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1; en = 0; v = 0; rdy = 1; ovf = 0; coarse = 24'h0; fine = 8'h0;
        tick(); tick(); tick();
        check("rst_arm", 32'(arm), 0);
        check("rst_txv", 32'(txv), 0);
        check("rst_txd", 32'(txd), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_to", 32'(to_p), 0);
    endtask

    task automatic check_rec(input int base, input int mbase, input int exp[8],
                             input string nm);
        if (dut_log.size() >= base + 8 && m_log.size() >= mbase + 8) begin
            for (int i = 0; i < 8; i++) begin
                check({nm, "_dut"}, 32'(dut_log[base + i]), exp[i]);
                check({nm, "_model"}, 32'(m_log[mbase + i]), exp[i]);
            end
        end else begin
            n_vec++; n_miss++;
            $display("FAIL %s: record missing, have %0d bytes", nm, dut_log.size() - base);
        end
    endtask

    initial begin
        int exp1[8] = '{'hA5, 'h00, 'h01, 'h23, 'h45, 'h7F, 'h00, 'h18};
        int exp2[8] = '{'hA5, 'h00, 'h00, 'h00, 'h00, 'h00, 'h01, 'h01};
        int base, mbase, k, off, nbase;
        bit nv;

        // Normal result with hand-computed record.
        do_reset();
        base = dut_log.size(); mbase = m_log.size();
        rst = 0; en = 1;
        tick();
        check("arm_early", 32'(arm), 0);
        tick();
        check("arm_rise", 32'(arm), 1);
        v = 1; coarse = 24'h012345; fine = 8'h7F;
        tick();
        v = 0;
        check("first_txv", 32'(txv), 1);
        check("first_byte", 32'(txd), 'hA5);
        wait_bytes(base + 8, 40, "rec1_bytes");
        check_rec(base, mbase, exp1, "rec1");

        // Timeout record.
        do_reset();
        base = dut_log.size(); mbase = m_log.size();
        rst = 0; en = 1;
        tick(); tick();
        k = 0;
        while (!to_p && k < 200) begin tick(); k++; end
        check("to_latency", 32'(k), TO);
        wait_bytes(base + 8, 40, "rec2_bytes");
        check_rec(base, mbase, exp2, "rec2");

        // Stray result in HOLD, then overflow result; then a clean record.
        wait_ph(M_HOLDING, 40, "hold1");
        v = 1; tick(); v = 0;
        wait_ph(M_WAITING, 40, "wait1");
        base = dut_log.size();
        v = 1; ovf = 1; coarse = 24'hABCDEF; fine = 8'h11;
        tick();
        v = 0; ovf = 0;
        wait_bytes(base + 8, 40, "rec3_bytes");
        if (dut_log.size() >= base + 8) check("flags_missed_ovf", 32'(dut_log[base + 6]), 'h06);
        wait_ph(M_WAITING, 40, "wait2");
        base = dut_log.size();
        v = 1; tick(); v = 0;
        wait_bytes(base + 8, 40, "rec4_bytes");
        if (dut_log.size() >= base + 8) check("flags_cleared", 32'(dut_log[base + 6]), 'h00);

        // Stray result on the same cycle as the final byte acceptance.
        wait_ph(M_WAITING, 40, "wait3");
        v = 1; tick(); v = 0;
        k = 0;
        while (!(ph == M_SENDING && recq.size() == 0) && k < 40) begin tick(); k++; end
        v = 1; tick(); v = 0;
        wait_ph(M_WAITING, 40, "wait4");
        base = dut_log.size();
        v = 1; tick(); v = 0;
        wait_bytes(base + 8, 40, "rec5_bytes");
        if (dut_log.size() >= base + 8) check("flags_missed_end", 32'(dut_log[base + 6]), 'h04);

        // Disable during WAIT aborts; disable during SEND completes the record.
        wait_ph(M_WAITING, 40, "wait5");
        base = dut_log.size();
        en = 0;
        tick();
        check("abort_arm", 32'(arm), 0);
        check("abort_busy", 32'(busy), 0);
        repeat (5) tick();
        check("abort_nobytes", 32'(dut_log.size()), 32'(base));
        en = 1;
        wait_ph(M_WAITING, 40, "wait6");
        base = dut_log.size();
        v = 1; tick(); v = 0; en = 0;
        k = 0;
        while (busy && k < 60) begin tick(); k++; end
        check("send_complete", 32'(dut_log.size()), 32'(base + 8));
        check("idle_busy", 32'(busy), 0);

        // Randomized run long enough to wrap seq.
        do_reset();
        base = dut_log.size(); nbase = n_done;
        rst = 0; off = 0; nv = 0;
        for (int c = 0; c < 25000 && (n_done - nbase) < 260; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            coarse = 24'($urandom); fine = 8'($urandom);
            ovf = ($urandom_range(0, 7) == 0);
            if (off > 0) off--;
            else if ($urandom_range(0, 149) == 0) off = int'($urandom_range(1, 12));
            en = (off == 0);
            if (ph == M_ARMING) nv = ($urandom_range(0, 9) == 0);
            v = 0;
            if (ph == M_WAITING && en && !nv) v = ($urandom_range(0, 5) == 0);
            else if (ph == M_HOLDING || ph == M_IDLE) v = ($urandom_range(0, 29) == 0);
            tick();
        end
        v = 0; rdy = 1;
        if (dut_log.size() > base + 8 * 256 + 1) begin
            check("seq_255", 32'(dut_log[base + 8 * 255 + 1]), 'hFF);
            check("seq_wrap", 32'(dut_log[base + 8 * 256 + 1]), 'h00);
        end else begin
            n_vec++; n_miss++;
            $display("FAIL seq_wrap: only %0d bytes logged", dut_log.size() - base);
        end

        // Reset in the middle of a record.
        en = 1;
        wait_ph(M_SENDING, 200, "send_rst");
        rst = 1;
        tick();
        check("rst_mid_send_txv", 32'(txv), 0);
        check("rst_mid_send_busy", 32'(busy), 0);
        rst = 0; en = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
